// File: rtl/mat4_vec_sequencer_if.sv
// ----------------------------------------------------------------------------
// mat4_vec_sequencer_if
//
// Purpose: bundles the job, dot-product operand/result and result-handshake
// signals of mat4_vec_sequencer into one interface.
//
// Signals:
//   mat_in       16*WIDTH  matrix, element (r,c) at [(4r+c)*WIDTH +: WIDTH]
//   vec_in        4*WIDTH  vector, element i at [i*WIDTH +: WIDTH]
//   valid_in      1        job request
//   ready_out     1        sequencer idle, job can be accepted
//   dp_x0..dp_x3  WIDTH    dot-product x operands (matrix row/column)
//   dp_y0..dp_y3  WIDTH    dot-product y operands (vector elements)
//   dp_result     WIDTH    dot-product unit output
//   res_out       4*WIDTH  result vector, element r at [r*WIDTH +: WIDTH]
//   valid_out     1        result valid
//   ready_in      1        downstream accepts the result
//   transpose_in  1        only with MAT4_VEC_TRANSPOSE_EN: compute M^T*v
//
// Modports:
//   slave  - the sequencer's view
//   master - the environment's view (front end + dot-product unit + sink)
//
// Optional feature macro: MAT4_VEC_TRANSPOSE_EN
// ----------------------------------------------------------------------------
interface mat4_vec_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [16*WIDTH-1:0]       mat_in;
    logic [4*WIDTH-1:0]        vec_in;
    logic                      valid_in;
    logic                      ready_out;
    logic signed [WIDTH-1:0]   dp_x0, dp_x1, dp_x2, dp_x3;
    logic signed [WIDTH-1:0]   dp_y0, dp_y1, dp_y2, dp_y3;
    logic signed [WIDTH-1:0]   dp_result;
    logic [4*WIDTH-1:0]        res_out;
    logic                      valid_out;
    logic                      ready_in;
`ifdef MAT4_VEC_TRANSPOSE_EN
    logic                      transpose_in;
`endif

    modport slave (
`ifdef MAT4_VEC_TRANSPOSE_EN
        input  transpose_in,
`endif
        input  mat_in, vec_in, valid_in, dp_result, ready_in,
        output ready_out, res_out, valid_out,
        output dp_x0, dp_x1, dp_x2, dp_x3,
        output dp_y0, dp_y1, dp_y2, dp_y3
    );

    modport master (
`ifdef MAT4_VEC_TRANSPOSE_EN
        output transpose_in,
`endif
        output mat_in, vec_in, valid_in, dp_result, ready_in,
        input  ready_out, res_out, valid_out,
        input  dp_x0, dp_x1, dp_x2, dp_x3,
        input  dp_y0, dp_y1, dp_y2, dp_y3
    );
endinterface

// File: rtl/mat4_vec_sequencer.sv
// ----------------------------------------------------------------------------
// mat4_vec_sequencer
//
// Purpose: accepts a 4x4 matrix and a 4-vector, streams one matrix row per
// cycle into a pipelined 4-element dot-product unit, collects the four scalar
// results DP_LATENCY edges later and offers the result vector on a
// valid/ready handshake.
//
// Ports:
//   clk_in  - system clock
//   rst_in  - asynchronous active-high reset; aborts any job in flight
//   bus     - mat4_vec_sequencer_if.slave (job input, dp operands/result,
//             result output handshake)
//
// Parameters:
//   WIDTH      - element width (signed), must match the interface WIDTH
//   DP_LATENCY - edges from operand sample to stable dp_result (>= 1)
//
// Optional feature macro: MAT4_VEC_TRANSPOSE_EN
//   When defined, bus.transpose_in is sampled with the job and columns are
//   streamed instead of rows, producing M^T*v with unchanged latency.
// ----------------------------------------------------------------------------
module mat4_vec_sequencer #(
    parameter int WIDTH      = 32,
    parameter int DP_LATENCY = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    mat4_vec_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              issue_q, issue_d;

    logic signed [WIDTH-1:0] mat_q [16];
    logic signed [WIDTH-1:0] vec_q [4];
`ifdef MAT4_VEC_TRANSPOSE_EN
    logic                    transpose_q;
`endif

    // Tag pipeline mirrors the dot-product unit: a tag enters together with
    // the operands and leaves exactly when the matching result is stable.
    logic [DP_LATENCY-1:0]   tag_vld_q;
    logic [1:0]              tag_row_q [DP_LATENCY];
    logic signed [WIDTH-1:0] res_q [4];

    logic                    accept;
    logic                    cap_vld;
    logic [1:0]              cap_row;
    logic signed [WIDTH-1:0] op_x [4];
    logic signed [WIDTH-1:0] op_y [4];

    assign accept  = (state_q == IDLE) && bus.valid_in;
    assign cap_vld = tag_vld_q[DP_LATENCY-1];
    assign cap_row = tag_row_q[DP_LATENCY-1];

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            issue_q <= 2'd0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    state_d = ISSUE;
                    issue_d = 2'd0;
                end
            end
            ISSUE: begin
                // issue wraps back to 0 after row 3
                issue_d = issue_q + 2'd1;
                if (issue_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_vld && (cap_row == 2'd3)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: operands are forced to zero outside ISSUE
    always_comb begin
        bus.ready_out = (state_q == IDLE);
        bus.valid_out = (state_q == DONE);
        for (int j = 0; j < 4; j++) begin
            op_x[j] = '0;
            op_y[j] = '0;
            if (state_q == ISSUE) begin
`ifdef MAT4_VEC_TRANSPOSE_EN
                op_x[j] = transpose_q ? mat_q[{2'(j), issue_q}]
                                      : mat_q[{issue_q, 2'(j)}];
`else
                op_x[j] = mat_q[{issue_q, 2'(j)}];
`endif
                op_y[j] = vec_q[j];
            end
        end
    end

    assign bus.dp_x0   = op_x[0];
    assign bus.dp_x1   = op_x[1];
    assign bus.dp_x2   = op_x[2];
    assign bus.dp_x3   = op_x[3];
    assign bus.dp_y0   = op_y[0];
    assign bus.dp_y1   = op_y[1];
    assign bus.dp_y2   = op_y[2];
    assign bus.dp_y3   = op_y[3];
    assign bus.res_out = {res_q[3], res_q[2], res_q[1], res_q[0]};

    // Job operand capture: pure data, loaded only on the accept edge
    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                mat_q[i] <= bus.mat_in[i*WIDTH +: WIDTH];
            end
            for (int i = 0; i < 4; i++) begin
                vec_q[i] <= bus.vec_in[i*WIDTH +: WIDTH];
            end
`ifdef MAT4_VEC_TRANSPOSE_EN
            transpose_q <= bus.transpose_in;
`endif
        end
    end

    // Tag pipeline and result capture; reset drops results still in flight
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_vld_q <= '0;
            for (int i = 0; i < DP_LATENCY; i++) begin
                tag_row_q[i] <= 2'd0;
            end
            for (int r = 0; r < 4; r++) begin
                res_q[r] <= '0;
            end
        end else begin
            tag_vld_q[0] <= (state_q == ISSUE);
            tag_row_q[0] <= issue_q;
            for (int i = 1; i < DP_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_row_q[i] <= tag_row_q[i-1];
            end
            if (cap_vld) begin
                res_q[cap_row] <= bus.dp_result;
            end
        end
    end

endmodule

// File: tb/tb_mat4_vec_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mat4_vec_sequencer
//
// Self-checking bench for mat4_vec_sequencer. Contains a 3-stage integer
// dot-product unit model and a matrix-vector reference model. Define
// MAT4_VEC_TRANSPOSE_EN to also exercise the transpose feature.
// ----------------------------------------------------------------------------
module tb_mat4_vec_sequencer;
    localparam int W = 32;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mat4_vec_sequencer_if #(.WIDTH(W)) bif ();

    mat4_vec_sequencer #(.WIDTH(W), .DP_LATENCY(L)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    // Dot-product unit model: L register stages, 32-bit wrapping arithmetic
    logic [W-1:0] dp_pipe [L];
    always @(posedge clk) begin
        dp_pipe[0] <= bif.dp_x0 * bif.dp_y0 + bif.dp_x1 * bif.dp_y1 +
                      bif.dp_x2 * bif.dp_y2 + bif.dp_x3 * bif.dp_y3;
        for (int i = 1; i < L; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign bif.dp_result = dp_pipe[L-1];

    // Reference: y = M*v (or M^T*v), 32-bit wrap
    function automatic logic [4*W-1:0] ref_mv(input logic [16*W-1:0] m,
                                             input logic [4*W-1:0] v,
                                             input bit tr);
        logic [4*W-1:0] res;
        for (int r = 0; r < 4; r++) begin
            int acc;
            acc = 0;
            for (int c = 0; c < 4; c++) begin
                int a, b;
                a = tr ? m[(4*c+r)*W +: W] : m[(4*r+c)*W +: W];
                b = v[c*W +: W];
                acc += a * b;
            end
            res[r*W +: W] = acc;
        end
        return res;
    endfunction

    function automatic logic [16*W-1:0] rand_mat();
        logic [16*W-1:0] m;
        for (int i = 0; i < 16; i++) m[i*W +: W] = $urandom;
        return m;
    endfunction

    function automatic logic [4*W-1:0] rand_vec();
        logic [4*W-1:0] v;
        for (int i = 0; i < 4; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    function automatic logic [16*W-1:0] ident_mat();
        logic [16*W-1:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[(5*i)*W +: W] = 1;
        return m;
    endfunction

    // Present a job for one edge (the accept edge); returns 1 ns after it.
    // Inputs are scrambled afterwards to show the job was latched.
    task automatic start_job(input logic [16*W-1:0] m, input logic [4*W-1:0] v);
        bif.mat_in   = m;
        bif.vec_in   = v;
        bif.valid_in = 1'b1;
        @(posedge clk); #1;
        bif.valid_in = 1'b0;
        bif.mat_in   = ~m;
        bif.vec_in   = ~v;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bif.valid_out !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        bif.valid_in = 1'b0;
        bif.ready_in = 1'b1;
        bif.mat_in   = '0;
        bif.vec_in   = '0;
`ifdef MAT4_VEC_TRANSPOSE_EN
        bif.transpose_in = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bif.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bif.ready_out); end
        n_tests++;
        if (bif.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bif.valid_out); end
        n_tests++;
        if (bif.res_out !== '0) begin n_fail++; $display("FAIL reset_res: got %h want 0", bif.res_out); end
        n_tests++;
        if ({bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3, bif.dp_y0, bif.dp_y1, bif.dp_y2, bif.dp_y3} !== '0) begin
            n_fail++; $display("FAIL reset_ops: operands not zero");
        end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        logic [4*W-1:0] v, exp;
        int lat;
        v = {32'd4, 32'd3, 32'd2, 32'd1};
        exp = ref_mv(ident_mat(), v, 1'b0);
        bif.ready_in = 1'b1;
        start_job(ident_mat(), v);
        wait_valid(lat);
        n_tests++;
        if (lat != 4 + L) begin n_fail++; $display("FAIL ident_latency: got %0d want %0d", lat, 4 + L); end
        n_tests++;
        if (bif.res_out !== exp) begin n_fail++; $display("FAIL ident_res: got %h want %h", bif.res_out, exp); end
        @(posedge clk); #1;
        n_tests++;
        if (bif.valid_out !== 1'b0) begin n_fail++; $display("FAIL ident_valid_pulse: got %b want 0", bif.valid_out); end
        n_tests++;
        if (bif.ready_out !== 1'b1) begin n_fail++; $display("FAIL ident_ready_back: got %b want 1", bif.ready_out); end
    endtask

    task automatic test_row_stream();
        logic [16*W-1:0] m;
        logic [4*W-1:0]  v, exp;
        int lat;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[(4*r+c)*W +: W] = r + 1;
        v = {4{32'd1}};
        exp = ref_mv(m, v, 1'b0);
        n_tests++;
        if ({bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3} !== '0) begin
            n_fail++; $display("FAIL stream_idle_ops: got %h want 0", {bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3});
        end
        start_job(m, v);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3} !== {4{32'(k + 1)}} ||
                {bif.dp_y0, bif.dp_y1, bif.dp_y2, bif.dp_y3} !== {4{32'd1}}) begin
                n_fail++;
                $display("FAIL stream_row%0d: got x=%h y=%h want x=%0d y=1", k,
                         {bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3},
                         {bif.dp_y0, bif.dp_y1, bif.dp_y2, bif.dp_y3}, k + 1);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3, bif.dp_y0, bif.dp_y1, bif.dp_y2, bif.dp_y3} !== '0) begin
            n_fail++; $display("FAIL stream_drain_ops: operands not zero after row 3");
        end
        wait_valid(lat);
        n_tests++;
        if (bif.res_out !== exp) begin n_fail++; $display("FAIL stream_res: got %h want %h", bif.res_out, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [16*W-1:0] m, m2;
        logic [4*W-1:0]  v, v2, exp, exp2;
        int lat;
        m = rand_mat(); v = rand_vec(); exp = ref_mv(m, v, 1'b0);
        m2 = rand_mat(); v2 = rand_vec(); exp2 = ref_mv(m2, v2, 1'b0);
        bif.ready_in = 1'b0;
        start_job(m, v);
        wait_valid(lat);
        n_tests++;
        if (lat != 4 + L) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, 4 + L); end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bif.valid_out !== 1'b1 || bif.ready_out !== 1'b0 || bif.res_out !== exp) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b ready=%b res=%h want 1 0 %h",
                         i, bif.valid_out, bif.ready_out, bif.res_out, exp);
            end
            // stray request while busy must be dropped
            if (i == 2) begin
                bif.mat_in = m2; bif.vec_in = v2; bif.valid_in = 1'b1;
            end else begin
                bif.valid_in = 1'b0;
            end
            @(posedge clk); #1;
        end
        bif.valid_in = 1'b0;
        bif.ready_in = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bif.valid_out !== 1'b0 || bif.ready_out !== 1'b1) begin
            n_fail++; $display("FAIL bp_handshake: got valid=%b ready=%b want 0 1", bif.valid_out, bif.ready_out);
        end
        start_job(m2, v2);
        wait_valid(lat);
        n_tests++;
        if (lat != 4 + L) begin n_fail++; $display("FAIL bp_next_latency: got %0d want %0d", lat, 4 + L); end
        n_tests++;
        if (bif.res_out !== exp2) begin n_fail++; $display("FAIL bp_next_res: got %h want %h", bif.res_out, exp2); end
        @(posedge clk); #1;
    endtask

    task automatic test_negative();
        logic [16*W-1:0] m;
        logic [4*W-1:0]  v, exp;
        int lat;
        m = rand_mat();
        m[0*W +: W] = -1; m[1*W +: W] = 2; m[2*W +: W] = -3; m[3*W +: W] = 4;
        v = {32'd8, 32'd7, -32'sd6, 32'd5};
        exp = ref_mv(m, v, 1'b0);
        bif.ready_in = 1'b1;
        start_job(m, v);
        wait_valid(lat);
        n_tests++;
        if (bif.res_out[W-1:0] !== 32'hFFFF_FFFA) begin
            n_fail++; $display("FAIL neg_row0: got %h want fffffffa", bif.res_out[W-1:0]);
        end
        n_tests++;
        if (bif.res_out !== exp) begin n_fail++; $display("FAIL neg_res: got %h want %h", bif.res_out, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [16*W-1:0] m;
        logic [4*W-1:0]  v, exp;
        int lat, dly;
        for (int j = 0; j < 8; j++) begin
            m = rand_mat(); v = rand_vec(); exp = ref_mv(m, v, 1'b0);
            dly = $urandom_range(0, 3);
            bif.ready_in = (dly == 0);
            start_job(m, v);
            wait_valid(lat);
            n_tests++;
            if (lat != 4 + L || bif.res_out !== exp) begin
                n_fail++; $display("FAIL rand%0d: got lat=%0d res=%h want lat=%0d res=%h", j, lat, bif.res_out, 4 + L, exp);
            end
            repeat (dly) begin @(posedge clk); #1; end
            bif.ready_in = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if (bif.valid_out !== 1'b0 || bif.ready_out !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_release: got valid=%b ready=%b want 0 1", j, bif.valid_out, bif.ready_out);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4*W-1:0] v;
        int lat;
        bif.ready_in = 1'b1;
        start_job(rand_mat(), rand_vec());
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bif.ready_out !== 1'b1 || bif.valid_out !== 1'b0 || bif.res_out !== '0) begin
            n_fail++; $display("FAIL arst_outputs: got ready=%b valid=%b res=%h want 1 0 0", bif.ready_out, bif.valid_out, bif.res_out);
        end
        n_tests++;
        if ({bif.dp_x0, bif.dp_x1, bif.dp_x2, bif.dp_x3, bif.dp_y0, bif.dp_y1, bif.dp_y2, bif.dp_y3} !== '0) begin
            n_fail++; $display("FAIL arst_ops: operands not zero during reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (bif.ready_out !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", bif.ready_out); end
        v = rand_vec();
        start_job(ident_mat(), v);
        wait_valid(lat);
        n_tests++;
        if (lat != 4 + L || bif.res_out !== v) begin
            n_fail++; $display("FAIL arst_next: got lat=%0d res=%h want lat=%0d res=%h", lat, bif.res_out, 4 + L, v);
        end
        @(posedge clk); #1;
    endtask

`ifdef MAT4_VEC_TRANSPOSE_EN
    task automatic test_transpose();
        logic [16*W-1:0] m;
        logic [4*W-1:0]  v;
        int lat;
        for (int i = 0; i < 16; i++) m[i*W +: W] = i;
        v = {32'd0, 32'd0, 32'd0, 32'd1};
        bif.ready_in = 1'b1;
        for (int t = 0; t < 2; t++) begin
            bif.transpose_in = (t == 0);
            start_job(m, v);
            bif.transpose_in = (t != 0);
            wait_valid(lat);
            n_tests++;
            if (t == 0 && bif.res_out !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
                n_fail++; $display("FAIL transpose_on: got %h want 3,2,1,0", bif.res_out);
            end else if (t == 1 && bif.res_out !== {32'd12, 32'd8, 32'd4, 32'd0}) begin
                n_fail++; $display("FAIL transpose_off: got %h want 12,8,4,0", bif.res_out);
            end
            n_tests++;
            if (lat != 4 + L) begin n_fail++; $display("FAIL transpose_latency%0d: got %0d want %0d", t, lat, 4 + L); end
            @(posedge clk); #1;
        end
        m = rand_mat(); v = rand_vec();
        bif.transpose_in = 1'b1;
        start_job(m, v);
        wait_valid(lat);
        n_tests++;
        if (bif.res_out !== ref_mv(m, v, 1'b1)) begin
            n_fail++; $display("FAIL transpose_rand: got %h want %h", bif.res_out, ref_mv(m, v, 1'b1));
        end
        @(posedge clk); #1;
        bif.transpose_in = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_row_stream();
        test_backpressure();
        test_negative();
        test_random();
        test_async_reset();
`ifdef MAT4_VEC_TRANSPOSE_EN
        test_transpose();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
